uart_rx_byte: RTL and testbench

- 8N1 UART receiver: the line-side consumer of the serial stream produced by the string-sender top level.
- Sits on the other end of the uart_tx wire, either in a loopback bench or in a second FPGA design.
- Recovers each byte and presents it as a 1-cycle valid pulse with the byte held on data.
- Flags framing errors and rejects glitch-length false start bits.

---
 rtl/uart_rx_byte_if.sv | 11 +
 rtl/uart_rx_byte.sv | 118 +++++++++++
 tb/tb_uart_rx_byte.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_byte_if.sv
// Serial line plus received-byte outputs of the 8N1 receiver.
interface uart_rx_byte_if;
   logic       rxd;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       busy;

   modport master (output rxd, input data, input valid, input frame_err, input busy);
   modport slave  (input rxd, output data, output valid, output frame_err, output busy);
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: start-bit glitch rejection, mid-bit sampling, framing-error flag.
//   state     | meaning
//   IDLE      | line high, waiting for a falling edge
//   START     | confirming start bit at its mid-point
//   DATA      | sampling 8 data bits, LSB first
//   STOP      | sampling stop bit
//   WAIT_HIGH | framing error seen, waiting for line to return high
module uart_rx_byte #(
   parameter int CYCLES_PER_BIT = 10416
) (
   input logic           clk,
   input logic           rst,
   uart_rx_byte_if.slave rx
);
   localparam int HALF_BIT = CYCLES_PER_BIT / 2;
   localparam int CW       = $clog2(CYCLES_PER_BIT);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF_BIT - 1);
   localparam logic [CW-1:0] BIT_M1  = CW'(CYCLES_PER_BIT - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    sync_q, sync_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    shreg_q, shreg_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d;
   logic          ferr_q, ferr_d;
   logic          busy_q, busy_d;
   logic          rxd_s;

   assign rxd_s = sync_q[1];

   always_comb begin
      sync_d  = {sync_q[0], rx.rxd};
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxd_s) state_d = START;
         end
         START: begin
            if (cnt_q == HALF_M1) begin
               state_d = rxd_s ? IDLE : DATA;
               idx_d   = 3'd0;
            end
         end
         DATA: begin
            // Bits stay in DATA, so the counter is restarted at each sample.
            if (cnt_q == BIT_M1) begin
               shreg_d = {rxd_s, shreg_q[7:1]};
               idx_d   = idx_q + 3'd1;
               cnt_d   = '0;
               if (idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (cnt_q == BIT_M1) begin
               if (rxd_s) begin
                  data_d  = shreg_q;
                  valid_d = 1'b1;
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_HIGH;
               end
            end
         end
         WAIT_HIGH: begin
            if (rxd_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         shreg_q <= 8'h00;
         data_q  <= 8'h00;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
      end
   end

   assign rx.data      = data_q;
   assign rx.valid     = valid_q;
   assign rx.frame_err = ferr_q;
   assign rx.busy      = busy_q;
endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte with a scoreboard of expected valid/frame_err pulses.
module tb_uart_rx_byte;
   localparam int CPB = 16;
   localparam int LAT = CPB / 2 + 9 * CPB;

   typedef struct {
      logic       err;
      logic [7:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   start_cyc = 0;
   logic busy_prev = 1'b0;
   logic [7:0] last_good = 8'h00;
   exp_t q[$];

   uart_rx_byte_if bus ();

   uart_rx_byte #(.CYCLES_PER_BIT(CPB)) dut (
      .clk (clk),
      .rst (rst),
      .rx  (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every pulse pops one expectation and checks kind, data and latency.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.busy && !busy_prev) start_cyc = cyc;
         if (bus.valid || bus.frame_err) begin
            tests++;
            assert (q.size() > 0) else begin
               fails++;
               $error("FAIL unexpected_pulse valid=%0b frame_err=%0b data=%h expected no pulse",
                      bus.valid, bus.frame_err, bus.data);
            end
            if (q.size() > 0) begin
               exp_t e;
               e = q.pop_front();
               tests++;
               assert ({bus.valid, bus.frame_err} === {~e.err, e.err}) else begin
                  fails++;
                  $error("FAIL pulse_kind valid/frame_err=%b expected %b",
                         {bus.valid, bus.frame_err}, {~e.err, e.err});
               end
               tests++;
               assert (bus.data === e.data) else begin
                  fails++;
                  $error("FAIL data got %h expected %h", bus.data, e.data);
               end
               tests++;
               assert ((cyc - start_cyc) === LAT) else begin
                  fails++;
                  $error("FAIL latency got %0d expected %0d", cyc - start_cyc, LAT);
               end
            end
         end
      end
      busy_prev = bus.busy;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_ok);
      exp_t e;
      e.err  = ~stop_ok;
      e.data = stop_ok ? b : last_good;
      q.push_back(e);
      if (stop_ok) last_good = b;
      bus.rxd = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 8; i++) begin
         bus.rxd = b[i];
         wait_cyc(CPB);
      end
      bus.rxd = stop_ok;
      wait_cyc(CPB);
   endtask

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      string s;
      logic [7:0] b3c;
      int waited;
      s = "hitsz2024311278";
      b3c = 8'h3C;
      bus.rxd = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(2);
      check("reset_data", bus.data, 8'h00);
      check("reset_flags", {5'd0, bus.valid, bus.frame_err, bus.busy}, 8'h00);

      // Single byte with idle line around it.
      send_frame(8'h68, 1'b1);
      bus.rxd = 1'b1;
      wait_cyc(40);
      check("single_queue_drained", 8'(q.size()), 8'd0);
      check("single_hold", bus.data, 8'h68);

      // Full string, zero inter-character gap.
      for (int i = 0; i < s.len(); i++) send_frame(s[i], 1'b1);
      bus.rxd = 1'b1;
      wait_cyc(40);
      check("string_queue_drained", 8'(q.size()), 8'd0);

      // Short glitch must be rejected as a false start.
      bus.rxd = 1'b0;
      wait_cyc(4);
      check("glitch_busy_rises", {7'd0, bus.busy}, 8'd1);
      wait_cyc(1);
      bus.rxd = 1'b1;
      waited = 0;
      while (bus.busy && waited < 10) begin
         wait_cyc(1);
         waited++;
      end
      check("glitch_busy_drops", {7'd0, bus.busy}, 8'd0);
      wait_cyc(20);
      check("glitch_data_hold", bus.data, last_good);

      // Framing error, line held low, then recovery.
      send_frame(8'hA5, 1'b0);
      wait_cyc(100);
      check("break_busy_high", {7'd0, bus.busy}, 8'd1);
      check("break_data_hold", bus.data, last_good);
      bus.rxd = 1'b1;
      wait_cyc(6);
      check("break_busy_low", {7'd0, bus.busy}, 8'd0);
      send_frame(8'h5A, 1'b1);
      wait_cyc(40);
      check("recover_queue_drained", 8'(q.size()), 8'd0);
      check("recover_data", bus.data, 8'h5A);

      // Reset during data bit 4 of 8'h3C.
      bus.rxd = 1'b0;
      wait_cyc(CPB);
      for (int i = 0; i < 4; i++) begin
         bus.rxd = b3c[i];
         wait_cyc(CPB);
      end
      bus.rxd = b3c[4];
      wait_cyc(CPB / 2);
      rst = 1'b1;
      #1;
      check("midreset_data", bus.data, 8'h00);
      check("midreset_flags", {5'd0, bus.valid, bus.frame_err, bus.busy}, 8'h00);
      last_good = 8'h00;
      bus.rxd = 1'b1;
      wait_cyc(3);
      rst = 1'b0;
      wait_cyc(CPB * 6);
      check("midreset_no_pulse_data", bus.data, 8'h00);
      send_frame(8'h31, 1'b1);
      wait_cyc(40);
      check("after_reset_data", bus.data, 8'h31);
      check("final_queue_drained", 8'(q.size()), 8'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
